boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_loader.sv | 107 ++++++++++
 tb/tb_boot_loader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// boot_loader
//   Copies WORDS 16-bit words from a combinational boot ROM into instruction
//   RAM starting at BASE and holds the CPU in reset until the copy finishes.
//   Each word takes a READ cycle (ROM word latched) and a WRITE cycle, and the
//   WRITE cycle stretches while ram_ready is low. A start pulse in DONE
//   restarts the copy.
// Ports
//   clk       : system clock, rising edge
//   reset     : asynchronous active-high reset; restarts the copy from word 0
//   start     : reload request, only honoured in DONE
//   rom_addr  : ROM word address (driven straight from the word counter)
//   rom_data  : combinational ROM read data
//   ram_addr  : RAM write address (BASE + word index, 16-bit wrap)
//   ram_din   : RAM write data
//   ram_we    : RAM write strobe; a write is taken on an edge with ram_ready=1
//   ram_ready : RAM write acceptance
//   cpu_reset : holds the CPU in reset while the copy is running
//   busy      : copy in progress
//   done      : copy complete
//   checksum  : mod-2^16 sum of the words written in the current/last copy
module boot_loader #(
   parameter int unsigned WORDS = 256,
   parameter logic [15:0] BASE  = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [15:0] rom_addr,
   input  logic [15:0] rom_data,
   output logic [15:0] ram_addr,
   output logic [15:0] ram_din,
   output logic        ram_we,
   input  logic        ram_ready,
   output logic        cpu_reset,
   output logic        busy,
   output logic        done,
   output logic [15:0] checksum
);

   localparam int unsigned CW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

   localparam logic [1:0] S_READ  = 2'd0;
   localparam logic [1:0] S_WRITE = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]    state;
   logic [CW-1:0] cnt;
   logic [15:0]   cnt_ext;

   assign cnt_ext  = {{(16 - CW){1'b0}}, cnt};
   assign rom_addr = cnt_ext;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_READ;
         cnt       <= '0;
         ram_addr  <= BASE;
         ram_din   <= '0;
         ram_we    <= 1'b0;
         checksum  <= '0;
         cpu_reset <= 1'b1;
         busy      <= 1'b1;
         done      <= 1'b0;
      end else begin
         case (state)
            S_READ: begin
               ram_din  <= rom_data;
               ram_addr <= BASE + cnt_ext;
               ram_we   <= 1'b1;
               state    <= S_WRITE;
            end
            S_WRITE: begin
               // ram_ready low: everything holds, the write strobe stays up
               if (ram_ready) begin
                  checksum <= checksum + ram_din;
                  ram_we   <= 1'b0;
                  if (cnt == LAST) begin
                     state     <= S_DONE;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     cpu_reset <= 1'b0;
                  end else begin
                     cnt   <= cnt + 1'b1;
                     state <= S_READ;
                  end
               end
            end
            S_DONE: begin
               if (start) begin
                  cnt       <= '0;
                  checksum  <= '0;
                  state     <= S_READ;
                  cpu_reset <= 1'b1;
                  busy      <= 1'b1;
                  done      <= 1'b0;
               end
            end
            default: begin
               state <= S_READ;
               ram_we <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader
//   Directed bench for boot_loader. Two instances: a default 256-word copy
//   and a 4-word copy at BASE 16'h0010. A reference model tracks edges since
//   the copy started, the expected write sequence and the running checksum.
module tb_boot_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b, start, ready, sel;
   logic [15:0] rom_a [256];
   logic [15:0] rom_b [256];

   logic [15:0] rom_addr_a, rom_data_a, ram_addr_a, ram_din_a, checksum_a;
   logic        ram_we_a, cpu_reset_a, busy_a, done_a;
   logic [15:0] rom_addr_b, rom_data_b, ram_addr_b, ram_din_b, checksum_b;
   logic        ram_we_b, cpu_reset_b, busy_b, done_b;

   assign rom_data_a = rom_a[rom_addr_a[7:0]];
   assign rom_data_b = rom_b[rom_addr_b[7:0]];

   boot_loader #(.WORDS(256), .BASE(16'h0000)) dut_a (
      .clk(clk), .reset(rst_a), .start(start),
      .rom_addr(rom_addr_a), .rom_data(rom_data_a),
      .ram_addr(ram_addr_a), .ram_din(ram_din_a), .ram_we(ram_we_a),
      .ram_ready(ready), .cpu_reset(cpu_reset_a), .busy(busy_a),
      .done(done_a), .checksum(checksum_a));

   boot_loader #(.WORDS(4), .BASE(16'h0010)) dut_b (
      .clk(clk), .reset(rst_b), .start(start),
      .rom_addr(rom_addr_b), .rom_data(rom_data_b),
      .ram_addr(ram_addr_b), .ram_din(ram_din_b), .ram_we(ram_we_b),
      .ram_ready(ready), .cpu_reset(cpu_reset_b), .busy(busy_b),
      .done(done_b), .checksum(checksum_b));

   // Selected DUT, seen through one set of signals
   logic        cur_reset, m_we, m_cpu, m_busy, m_done;
   logic [15:0] m_rom_addr, m_addr, m_din, m_sum, base;
   int          words;
   assign cur_reset  = sel ? rst_b : rst_a;
   assign m_we       = sel ? ram_we_b : ram_we_a;
   assign m_cpu      = sel ? cpu_reset_b : cpu_reset_a;
   assign m_busy     = sel ? busy_b : busy_a;
   assign m_done     = sel ? done_b : done_a;
   assign m_rom_addr = sel ? rom_addr_b : rom_addr_a;
   assign m_addr     = sel ? ram_addr_b : ram_addr_a;
   assign m_din      = sel ? ram_din_b : ram_din_a;
   assign m_sum      = sel ? checksum_b : checksum_a;
   assign base       = sel ? 16'h0010 : 16'h0000;
   assign words      = sel ? 4 : 256;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] mrom(input int i);
      return sel ? rom_b[i] : rom_a[i];
   endfunction

   // Reference model: copy takes 2 edges per word plus any stall edges the
   // stimulus introduces; done from edge 2*words+stalls on.
   int          edge_n, wr_idx, stalls;
   logic [15:0] exp_sum;
   bit          chk_en, exp_d;

   always @(posedge clk or posedge cur_reset) begin
      if (cur_reset) begin
         edge_n  = 0;
         wr_idx  = 0;
         exp_sum = '0;
      end else begin
         if (chk_en && m_we && ready) begin
            if (wr_idx < words) begin
               check("wr_addr", m_addr, base + 16'(wr_idx));
               check("wr_data", m_din, mrom(wr_idx));
               exp_sum = exp_sum + mrom(wr_idx);
            end else begin
               checks++;
               errors++;
               $display("FAIL extra_write: write %0d beyond %0d words", wr_idx, words);
            end
            wr_idx++;
         end
         if (chk_en && edge_n >= 2 * words + stalls && start) begin
            edge_n  = 0;
            wr_idx  = 0;
            exp_sum = '0;
         end else begin
            edge_n++;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en && !cur_reset) begin
         exp_d = (edge_n >= 2 * words + stalls);
         check("done", m_done, exp_d);
         check("busy", m_busy, !exp_d);
         check("cpu_reset", m_cpu, !exp_d);
         check("checksum", m_sum, exp_sum);
         if (exp_d) check("we_idle", m_we, 0);
         else if (stalls == 0) begin
            check("we_phase", m_we, edge_n % 2);
            check("rom_addr", m_rom_addr, edge_n / 2);
         end
      end
   end

   task automatic wait_done(input int bound);
      int n = 0;
      while (!m_done && n < bound) begin
         @(negedge clk);
         n++;
      end
      check("done_timeout", m_done, 1);
   endtask

   task automatic wait_edge(input int target);
      int n = 0;
      while (edge_n != target && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("edge_timeout", edge_n, target);
   endtask

   task automatic restart_a(input int stall_n);
      @(negedge clk);
      rst_a = 1'b1;
      #2;
      stalls = stall_n;
      rst_a = 1'b0;
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1; start = 1'b0; ready = 1'b1; sel = 1'b0;
      chk_en = 1'b0; stalls = 0;
      for (int i = 0; i < 256; i++) begin
         rom_a[i] = 16'(i + 1);
         rom_b[i] = 16'hFFFF;
      end

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_rom_addr", rom_addr_a, 16'h0000);
      check("rst_ram_addr", ram_addr_a, 16'h0000);
      check("rst_ram_din", ram_din_a, 16'h0000);
      check("rst_we", ram_we_a, 0);
      check("rst_sum", checksum_a, 16'h0000);
      check("rst_cpu", cpu_reset_a, 1);
      check("rst_busy", busy_a, 1);
      check("rst_done", done_a, 0);
      check("rst_b_ram_addr", ram_addr_b, 16'h0010);

      // Full 256-word copy, automatic after reset release
      chk_en = 1'b1;
      #2 rst_a = 1'b0;
      wait_done(600);
      check("t1_done_edge", edge_n, 512);
      check("t1_sum", checksum_a, 16'h8080);
      check("t1_writes", wr_idx, 256);
      check("t1_cpu", cpu_reset_a, 0);

      // Three-cycle stall on the word-5 write
      restart_a(3);
      begin
         int n = 0;
         while (!(ram_we_a && ram_addr_a == 16'h0005) && n < 40) begin
            @(negedge clk);
            n++;
         end
      end
      check("t2_reach_w5", ram_addr_a, 16'h0005);
      ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("t2_stall_we", ram_we_a, 1);
         check("t2_stall_addr", ram_addr_a, 16'h0005);
         check("t2_stall_din", ram_din_a, 16'h0006);
      end
      ready = 1'b1;
      wait_done(600);
      check("t2_done_edge", edge_n, 515);
      check("t2_sum", checksum_a, 16'h8080);

      // start pulsed while busy is ignored
      restart_a(0);
      wait_edge(99);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("t3_busy", busy_a, 1);
      wait_done(600);
      check("t3_done_edge", edge_n, 512);
      check("t3_sum", checksum_a, 16'h8080);

      // Reload from DONE with a new ROM image
      repeat (3) @(negedge clk);
      for (int i = 0; i < 256; i++) rom_a[i] = 16'h0001;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("t4_cpu", cpu_reset_a, 1);
      check("t4_busy", busy_a, 1);
      check("t4_done", done_a, 0);
      wait_done(600);
      check("t4_done_edge", edge_n, 512);
      check("t4_sum", checksum_a, 16'h0100);

      // Asynchronous reset during word 100
      for (int i = 0; i < 256; i++) rom_a[i] = 16'(i + 1);
      restart_a(0);
      wait_edge(201);
      check("t5_pre_we", ram_we_a, 1);
      check("t5_pre_addr", ram_addr_a, 16'd100);
      @(posedge clk);
      #2 rst_a = 1'b1;
      #1;
      check("t5_we", ram_we_a, 0);
      check("t5_cpu", cpu_reset_a, 1);
      check("t5_busy", busy_a, 1);
      check("t5_done", done_a, 0);
      check("t5_sum", checksum_a, 16'h0000);
      check("t5_rom_addr", rom_addr_a, 16'h0000);
      @(negedge clk);
      #2 rst_a = 1'b0;
      @(negedge clk);
      check("t5_first_we", ram_we_a, 1);
      check("t5_first_addr", ram_addr_a, 16'h0000);
      wait_done(600);
      check("t5_done_edge", edge_n, 512);
      check("t5_sum_end", checksum_a, 16'h8080);

      // Small instance: WORDS=4, BASE=16'h0010, ROM all 16'hFFFF
      chk_en = 1'b0;
      @(negedge clk);
      rst_a = 1'b1;
      #1 sel = 1'b1;
      @(negedge clk);
      chk_en = 1'b1;
      #2 rst_b = 1'b0;
      wait_done(40);
      check("t6_done_edge", edge_n, 8);
      check("t6_sum", checksum_b, 16'hFFFC);
      check("t6_writes", wr_idx, 4);
      check("t6_last_addr", ram_addr_b, 16'h0013);
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
